// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: sequencer and register stage around the combinational ALU.
// Takes one instruction at a time, holds ACC/BR/IR steady for the ALU, fires
// exactly one ALU strobe for one cycle, writes the result back and retires
// the instruction with a one-cycle done pulse and an error code.
module alu_exec_ctrl #(
  parameter int DATA_W     = 16,
  parameter int ST_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  input  logic [DATA_W-1:0] in_data,
  output logic              C8,
  output logic              C9,
  output logic              C13,
  output logic              C15,
  output logic              C16,
  output logic              C17,
  output logic              C18,
  output logic              C19,
  output logic              C20,
  output logic              C21,
  output logic [DATA_W-1:0] acc_q,
  output logic [DATA_W-1:0] br_q,
  output logic [15:0]       ir_q,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [3:0]        alu_flags,
  output logic [3:0]        flags_q,
  output logic              st_valid,
  output logic [DATA_W-1:0] st_data,
  input  logic              st_ready,
  output logic              done,
  output logic [1:0]        err
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_STORE = 8'h02;
  localparam logic [7:0] OP_DIV   = 8'h06;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_DIV0  = 2'b01;
  localparam logic [1:0] ERR_ILL   = 2'b10;
  localparam logic [1:0] ERR_STTMO = 2'b11;

  localparam logic [7:0] CNT_LAST = 8'(ST_TIMEOUT - 1);

  // Strobe vector bit order: {C21,C20,C19,C18,C17,C16,C15,C13,C9,C8}
  function automatic logic [9:0] decode_strb(input logic [7:0] op);
    logic [9:0] s;
    s = '0;
    case (op)
      8'h03: s[1] = 1'b1;  // ADD  C9
      8'h04: s[2] = 1'b1;  // SUB  C13
      8'h05: s[3] = 1'b1;  // MUL  C15
      8'h06: s[4] = 1'b1;  // DIV  C16
      8'h07: s[5] = 1'b1;  // SHL  C17
      8'h08: s[6] = 1'b1;  // SHR  C18
      8'h09: s[7] = 1'b1;  // AND  C19
      8'h0A: s[8] = 1'b1;  // OR   C20
      8'h0B: s[9] = 1'b1;  // NOT  C21
      8'h0C: s[0] = 1'b1;  // CLR  C8
      default: s = '0;
    endcase
    return s;
  endfunction

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   acc_d, br_d;
  logic [15:0]         ir_d;
  logic [3:0]          flags_d;
  logic [9:0]          strb_q, strb_d;
  logic [1:0]          err_q, err_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [7:0]          op;
  logic                op_is_alu;

  assign op        = ir_q[15:8];
  assign op_is_alu = |decode_strb(op);

  // Next-state, register write-back and store wait counter
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    br_d    = br_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    strb_d  = '0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ir_d    = in_instr;
          br_d    = in_data;
          // Strobe is registered here so it is glitch-free for the whole EXEC cycle
          strb_d  = decode_strb(in_instr[15:8]);
          cnt_d   = '0;
          err_d   = ERR_OK;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op == OP_STORE) begin
          if (st_ready) begin
            state_d = S_DONE;
          end else if (cnt_q == CNT_LAST) begin
            err_d   = ERR_STTMO;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          state_d = S_DONE;
          if (op == OP_LOAD) begin
            acc_d = br_q;
          end else if (op_is_alu) begin
            acc_d   = alu_out;
            flags_d = alu_flags;
            if (op == OP_DIV && br_q == '0) err_d = ERR_DIV0;
          end else if (op != OP_NOP) begin
            err_d = ERR_ILL;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and register update; reset aborts any instruction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      br_q    <= '0;
      ir_q    <= '0;
      flags_q <= '0;
      strb_q  <= '0;
      err_q   <= ERR_OK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      br_q    <= br_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
      strb_q  <= strb_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready = (state_q == S_IDLE);
  assign st_valid = (state_q == S_EXEC) && (op == OP_STORE);
  assign st_data  = acc_q;
  assign done     = (state_q == S_DONE);
  assign err      = done ? err_q : ERR_OK;

  assign C8  = strb_q[0];
  assign C9  = strb_q[1];
  assign C13 = strb_q[2];
  assign C15 = strb_q[3];
  assign C16 = strb_q[4];
  assign C17 = strb_q[5];
  assign C18 = strb_q[6];
  assign C19 = strb_q[7];
  assign C20 = strb_q[8];
  assign C21 = strb_q[9];

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: behavioural ALU stub, table of instructions with
// expected ACC/FLAGS/err, scoreboard queue popped on done, plus STORE stall,
// STORE timeout and reset-during-stall sequences.
module tb_alu_exec_ctrl;

  localparam int TMO = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] in_instr, in_data;
  logic        C8, C9, C13, C15, C16, C17, C18, C19, C20, C21;
  logic [15:0] acc_q, br_q, ir_q, alu_out, st_data;
  logic [3:0]  alu_flags, flags_q;
  logic        st_valid, st_ready, done;
  logic [1:0]  err;

  alu_exec_ctrl #(.DATA_W(16), .ST_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_data(in_data),
    .C8(C8), .C9(C9), .C13(C13), .C15(C15), .C16(C16), .C17(C17),
    .C18(C18), .C19(C19), .C20(C20), .C21(C21),
    .acc_q(acc_q), .br_q(br_q), .ir_q(ir_q),
    .alu_out(alu_out), .alu_flags(alu_flags), .flags_q(flags_q),
    .st_valid(st_valid), .st_data(st_data), .st_ready(st_ready),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: result selected by whichever strobe is high, else 0
  logic [31:0] t32;
  logic [16:0] t17;
  logic [15:0] r;
  logic        cf, of, div0;
  always_comb begin
    r = '0; cf = 1'b0; of = 1'b0; div0 = 1'b0; t32 = '0; t17 = '0;
    if (C9) begin
      t17 = {1'b0, acc_q} + {1'b0, br_q}; r = t17[15:0]; cf = t17[16];
      of = (acc_q[15] == br_q[15]) && (r[15] != acc_q[15]);
    end else if (C13) begin
      r = acc_q - br_q; cf = acc_q < br_q;
      of = (acc_q[15] != br_q[15]) && (r[15] != acc_q[15]);
    end else if (C15) begin
      t32 = {16'h0, acc_q} * {16'h0, br_q}; r = t32[15:0]; cf = |t32[31:16]; of = cf;
    end else if (C16) begin
      if (br_q == 16'h0) begin r = 16'hFFFF; div0 = 1'b1; end
      else r = acc_q / br_q;
    end else if (C17) begin
      t32 = {16'h0, acc_q} << ir_q[3:0]; r = t32[15:0]; cf = t32[16];
    end else if (C18) begin
      t32 = {acc_q, 16'h0} >> ir_q[3:0]; r = t32[31:16]; cf = t32[15];
    end else if (C19) r = acc_q & br_q;
    else if (C20) r = acc_q | br_q;
    else if (C21) r = ~acc_q;
    else if (C8)  r = 16'h0;
    alu_out   = r;
    alu_flags = div0 ? 4'b0100 : {r == 16'h0, cf, of, r[15]};
  end

  typedef struct {
    logic [15:0] instr, data, acc;
    logic [3:0]  flags;
    logic [1:0]  err;
    int          strb;
  } vec_t;

  typedef struct {
    logic [15:0] acc;
    logic [3:0]  flags;
    logic [1:0]  err;
    int          done_cyc;
    int          strb;
    int          st_cyc;
  } exp_t;

  vec_t vecs[18];
  exp_t sbq[$];
  int   n_chk = 0, n_fail = 0;
  int   st_delay = 0;
  int   strb_cnt = 0, st_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Monitor: counts strobe/st_valid cycles, drives st_ready, pops scoreboard on done
  initial begin
    exp_t e;
    st_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        strb_cnt = 0; st_cyc = 0; st_ready = 1'b0;
      end else begin
        if ({C21, C20, C19, C18, C17, C16, C15, C13, C9, C8} != 10'h0) strb_cnt++;
        if (st_valid) begin
          st_cyc++;
          if (sbq.size() > 0) chk("st_data", st_data, sbq[0].acc);
        end
        if (done) begin
          if (sbq.size() == 0) chk("unexpected_done", done, 1'b0);
          else begin
            e = sbq.pop_front();
            chk("acc", acc_q, e.acc);
            chk("flags", flags_q, e.flags);
            chk("err", err, e.err);
            chk("strobe_cycles", strb_cnt, e.strb);
            if (e.done_cyc >= 0) chk("done_latency", cyc, e.done_cyc);
            if (e.st_cyc >= 0) chk("st_valid_cycles", st_cyc, e.st_cyc);
          end
          strb_cnt = 0; st_cyc = 0;
        end
        st_ready = (st_delay >= 0) && (st_cyc > st_delay);
      end
    end
  end

  task automatic run_instr(input logic [15:0] instr, input logic [15:0] data,
                           input logic [15:0] eacc, input logic [3:0] efl,
                           input logic [1:0] eerr, input int estrb,
                           input int est, input int dly);
    exp_t e;
    int   n;
    st_delay = dly;
    @(negedge clk);
    in_instr = instr; in_data = data; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin
      chk("accept_timeout", in_ready, 1'b1);
      in_valid = 1'b0;
      return;
    end
    e = '{eacc, efl, eerr, (est < 0) ? cyc + 2 : -1, estrb, est};
    sbq.push_back(e);
    @(negedge clk);
    in_valid = 1'b0; in_instr = 16'($urandom); in_data = 16'($urandom);
    n = 0;
    while (sbq.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (sbq.size() != 0) begin
      chk("done_timeout", sbq.size(), 0);
      sbq.delete();
    end
  endtask

  // Main sequence
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_data = '0;
    vecs[0]  = '{16'h0100, 16'h7FFF, 16'h7FFF, 4'b0000, 2'b00, 0}; // LOAD
    vecs[1]  = '{16'h0300, 16'h0001, 16'h8000, 4'b0011, 2'b00, 1}; // ADD overflow
    vecs[2]  = '{16'h0100, 16'h0000, 16'h0000, 4'b0011, 2'b00, 0}; // LOAD keeps flags
    vecs[3]  = '{16'h0400, 16'h0001, 16'hFFFF, 4'b0101, 2'b00, 1}; // SUB borrow
    vecs[4]  = '{16'h0C00, 16'h5555, 16'h0000, 4'b1000, 2'b00, 1}; // CLR
    vecs[5]  = '{16'h0100, 16'h1234, 16'h1234, 4'b1000, 2'b00, 0}; // LOAD
    vecs[6]  = '{16'h0600, 16'h0000, 16'hFFFF, 4'b0100, 2'b01, 1}; // DIV by zero
    vecs[7]  = '{16'h0100, 16'h8001, 16'h8001, 4'b0100, 2'b00, 0}; // LOAD
    vecs[8]  = '{16'h0701, 16'h0000, 16'h0002, 4'b0100, 2'b00, 1}; // SHL 1
    vecs[9]  = '{16'hFF00, 16'h1111, 16'h0002, 4'b0100, 2'b10, 0}; // illegal FF
    vecs[10] = '{16'h0000, 16'h2222, 16'h0002, 4'b0100, 2'b00, 0}; // NOP
    vecs[11] = '{16'h0100, 16'h00F0, 16'h00F0, 4'b0100, 2'b00, 0}; // LOAD
    vecs[12] = '{16'h0900, 16'h0F3C, 16'h0030, 4'b0000, 2'b00, 1}; // AND
    vecs[13] = '{16'h0A00, 16'h0F00, 16'h0F30, 4'b0000, 2'b00, 1}; // OR
    vecs[14] = '{16'h0B00, 16'h0000, 16'hF0CF, 4'b0001, 2'b00, 1}; // NOT
    vecs[15] = '{16'h0804, 16'h0000, 16'h0F0C, 4'b0100, 2'b00, 1}; // SHR 4
    vecs[16] = '{16'h0500, 16'h0002, 16'h1E18, 4'b0000, 2'b00, 1}; // MUL
    vecs[17] = '{16'h0600, 16'h0004, 16'h0786, 4'b0000, 2'b00, 1}; // DIV
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_acc", acc_q, 16'h0);
    chk("rst_br", br_q, 16'h0);
    chk("rst_ir", ir_q, 16'h0);
    chk("rst_flags", flags_q, 4'h0);
    chk("rst_strobes", {C21, C20, C19, C18, C17, C16, C15, C13, C9, C8}, 10'h0);
    chk("rst_st_valid", st_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 2'b00);

    for (int i = 0; i < 18; i++)
      run_instr(vecs[i].instr, vecs[i].data, vecs[i].acc, vecs[i].flags,
                vecs[i].err, vecs[i].strb, -1, 0);
    run_instr(16'h0D00, 16'h0000, 16'h0786, 4'b0000, 2'b10, 0, -1, 0);   // illegal 0D

    // STORE, st_ready low for 5 cycles: st_valid held 6 cycles
    run_instr(16'h0200, 16'h0000, 16'h0786, 4'b0000, 2'b00, 0, 6, 5);
    // STORE, st_ready never: abort after TMO cycles
    run_instr(16'h0200, 16'h0000, 16'h0786, 4'b0000, 2'b11, 0, TMO, -1);

    // Reset during a STORE stall: abort silently, then resume normally
    st_delay = -1;
    @(negedge clk);
    in_instr = 16'h0200; in_data = 16'h0000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("stall_st_valid", st_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_acc", acc_q, 16'h0);
    chk("abort_flags", flags_q, 4'h0);
    chk("abort_st_valid", st_valid, 1'b0);
    chk("abort_done", done, 1'b0);
    repeat (4) @(negedge clk);
    run_instr(16'h0100, 16'h00AA, 16'h00AA, 4'b0000, 2'b00, 0, -1, 0);
    run_instr(16'h0300, 16'h0001, 16'h00AB, 4'b0000, 2'b00, 1, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
